// File: rtl/dmem_if.sv
// Bus between the EX/MEM register and the data-memory stage.
// Handshake: a request (MemRead_i | MemWrite_i) acts as "valid"; the stage
// accepts it when it is seen in IDLE, and the requester must hold every
// request field stable for as long as stall_o is high. The access has
// completed in the first cycle after acceptance where stall_o is low (DONE).
// In that cycle ReadData_o and err_o are valid for MEM/WB.
`timescale 1ns/1ps
interface dmem_if;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [2:0]  funct3_i;
   logic [31:0] Addr_i;
   logic [31:0] WriteData_i;
   logic [31:0] ReadData_o;
   logic        stall_o;
   logic        err_o;
   logic [1:0]  dbg_state;

   modport master (
      output MemRead_i, MemWrite_i, funct3_i, Addr_i, WriteData_i,
      input  ReadData_o, stall_o, err_o, dbg_state
   );

   modport slave (
      input  MemRead_i, MemWrite_i, funct3_i, Addr_i, WriteData_i,
      output ReadData_o, stall_o, err_o, dbg_state
   );
endinterface

// File: rtl/dmem_stage.sv
// RV32 data-memory stage: multi-cycle loads/stores against an internal word
// array, stalling the pipeline while an access is in flight.
`timescale 1ns/1ps
module dmem_stage #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input logic   clk_i,
   input logic   rst_i,
   dmem_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_commit;
   logic          w_req;

   logic [31:0]   r_mem [DEPTH];
   logic [31:0]   r_rdata;
   logic          r_err;

   logic [AW-1:0] w_idx;
   logic [1:0]    w_lane;
   logic [31:0]   w_word;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic          w_f3_ok;
   logic          w_misal;
   logic          w_err;
   logic          w_unused;

   assign w_req  = bus.MemRead_i | bus.MemWrite_i;
   assign w_idx  = bus.Addr_i[AW+1:2];
   assign w_lane = bus.Addr_i[1:0];
   assign w_word = r_mem[w_idx];

   // Upper address bits are deliberately ignored: accesses wrap modulo DEPTH.
   assign w_unused = ^bus.Addr_i[31:AW+2];

   // Next-state and commit strobe; the access commits on the last BUSY edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = CNT_INIT;
            end
         end
         S_BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_DONE;
               w_commit    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and latency counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Legality: BU/HU have no store form; H needs half alignment, W word alignment.
   always_comb begin
      w_f3_ok = 1'b0;
      case (bus.funct3_i)
         3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
         3'b100, 3'b101:         w_f3_ok = ~bus.MemWrite_i;
         default:                w_f3_ok = 1'b0;
      endcase
      w_misal = ((bus.funct3_i[1:0] == 2'b01) & w_lane[0]) |
                ((bus.funct3_i[1:0] == 2'b10) & (w_lane != 2'b00));
      w_err   = ~w_f3_ok | w_misal | (bus.MemRead_i & bus.MemWrite_i);
   end

   // Store byte enables and lane-replicated store data.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = bus.WriteData_i;
      case (bus.funct3_i[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{bus.WriteData_i[7:0]}};
         end
         2'b01: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{bus.WriteData_i[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = bus.WriteData_i;
         end
      endcase
   end

   // Load lane selection followed by sign or zero extension.
   always_comb begin
      w_byte = 8'h00;
      case (w_lane)
         2'd0:    w_byte = w_word[7:0];
         2'd1:    w_byte = w_word[15:8];
         2'd2:    w_byte = w_word[23:16];
         default: w_byte = w_word[31:24];
      endcase
      w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
      case (bus.funct3_i)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'h000000, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'h0000, w_half};
         default: w_load = w_word;
      endcase
   end

   // Array write at commit; not reset, and suppressed if reset is active.
   always_ff @(posedge clk_i) begin
      if (w_commit & bus.MemWrite_i & ~w_err & ~rst_i) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

   // Load result and error pulse, both valid during DONE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (w_commit) begin
            if (w_err) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end else if (bus.MemRead_i) begin
               r_rdata <= w_load;
            end
         end
      end
   end

   assign bus.ReadData_o = r_rdata;
   assign bus.err_o      = r_err;
   assign bus.dbg_state  = r_state;
   assign bus.stall_o    = ~rst_i & (((r_state == S_IDLE) & w_req) | (r_state == S_BUSY));

endmodule

// File: tb/tb_dmem_stage.sv
// Directed bench for dmem_stage (DEPTH=1024, LATENCY=2).
`timescale 1ns/1ps
module tb_dmem_stage;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   logic [31:0] last_rd;

   dmem_if bus ();

   dmem_stage #(.DEPTH(1024), .LATENCY(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      bus.MemRead_i   = 1'b0;
      bus.MemWrite_i  = 1'b0;
      bus.funct3_i    = 3'b000;
      bus.Addr_i      = '0;
      bus.WriteData_i = '0;
   endtask

   // Drive one access (called just after a rising edge) and check its DONE cycle.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_rd);
      int n_stall;
      bit done;
      bus.MemRead_i   = rd;
      bus.MemWrite_i  = wr;
      bus.funct3_i    = f3;
      bus.Addr_i      = addr;
      bus.WriteData_i = wdata;
      n_stall = 0;
      done    = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.stall_o) n_stall++;
         else done = 1'b1;
      end
      check({tag, "_done"},  32'(done), 32'd1);
      check({tag, "_stall"}, n_stall, 32'd3);
      check({tag, "_state"}, 32'(bus.dbg_state), 32'd2);
      check({tag, "_err"},   32'(bus.err_o), 32'(exp_err));
      check({tag, "_rd"},    bus.ReadData_o, exp_rd);
      last_rd = exp_rd;
      @(posedge clk);
      #1;
      check({tag, "_errpulse"}, 32'(bus.err_o), 32'd0);
      idle_inputs();
   endtask

   task automatic store(input string tag, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data);
      access(tag, 1'b0, 1'b1, f3, addr, data, 1'b0, last_rd);
   endtask

   task automatic load(input string tag, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] exp);
      access(tag, 1'b1, 1'b0, f3, addr, 32'h0, 1'b0, exp);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      last_rd  = '0;
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rd",    bus.ReadData_o, 32'h0);
      check("rst_err",   32'(bus.err_o), 32'd0);
      check("rst_stall", 32'(bus.stall_o), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // word store then load
      store("sw10", 3'b010, 32'h10, 32'hDEADBEEF);
      load ("lw10", 3'b010, 32'h10, 32'hDEADBEEF);

      // sub-word loads with extension
      store("sw20", 3'b010, 32'h20, 32'h80FF7F01);
      load ("lb23",  3'b000, 32'h23, 32'hFFFFFF80);
      load ("lbu23", 3'b100, 32'h23, 32'h00000080);
      load ("lh22",  3'b001, 32'h22, 32'hFFFF80FF);
      load ("lhu20", 3'b101, 32'h20, 32'h00007F01);

      // sub-word stores keep other lanes
      store("sw20b", 3'b010, 32'h20, 32'h11223344);
      store("sb21",  3'b000, 32'h21, 32'h000000AA);
      load ("lw20a", 3'b010, 32'h20, 32'h1122AA44);
      store("sh22",  3'b001, 32'h22, 32'h0000BEEF);
      load ("lw20b", 3'b010, 32'h20, 32'hBEEFAA44);

      // error cases: no write, ReadData cleared, one-cycle err pulse
      access("lw12_mis", 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0);
      load  ("lw10_b",   3'b010, 32'h10, 32'hDEADBEEF);
      access("sh11_mis", 1'b0, 1'b1, 3'b001, 32'h11, 32'h0000FFFF, 1'b1, 32'h0);
      load  ("lw10_c",   3'b010, 32'h10, 32'hDEADBEEF);
      access("f3_011",   1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
      load  ("lw20_c",   3'b010, 32'h20, 32'hBEEFAA44);
      access("sbu_st",   1'b0, 1'b1, 3'b100, 32'h20, 32'h55, 1'b1, 32'h0);
      access("rdwr",     1'b1, 1'b1, 3'b010, 32'h20, 32'h66, 1'b1, 32'h0);
      load  ("lw20_d",   3'b010, 32'h20, 32'hBEEFAA44);

      // reset during the second BUSY cycle of a store
      store("sw30", 3'b010, 32'h30, 32'hCAFEF00D);
      load ("lw30", 3'b010, 32'h30, 32'hCAFEF00D);
      bus.MemRead_i   = 1'b0;
      bus.MemWrite_i  = 1'b1;
      bus.funct3_i    = 3'b010;
      bus.Addr_i      = 32'h30;
      bus.WriteData_i = 32'h00000005;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("mid_stall_pre", 32'(bus.stall_o), 32'd1);
      rst = 1'b1;
      idle_inputs();
      #1;
      check("mid_stall", 32'(bus.stall_o), 32'd0);
      check("mid_rd",    bus.ReadData_o, 32'h0);
      check("mid_state", 32'(bus.dbg_state), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_rd = '0;
      @(posedge clk);
      #1;
      load("lw30_after", 3'b010, 32'h30, 32'hCAFEF00D);

      // address wrap and back-to-back loads (3 on / 1 off each)
      store("sw1000", 3'b010, 32'h1000, 32'h12345678);
      load ("lw0_a",  3'b010, 32'h0, 32'h12345678);
      load ("lw0_b",  3'b010, 32'h0, 32'h12345678);
      load ("lw10_d", 3'b010, 32'h10, 32'hDEADBEEF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
